instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Writer side of the 16-bit instruction register interface. On a fetch request from the control unit it reads one instruction word from instruction memory at the current PC, using a ready-based handshake. It then presents the word on ir_data with a one-cycle ir_write strobe to the IR, and advances the PC. It also owns the PC register, which the control unit loads for branches and jumps.

Parameters:
ADDR_W, 16, PC and memory address width
DATA_W, 16, instruction word width; matches the IR
RESET_PC, 16'h0000, PC value after reset
PC_INC, 1, PC increment per fetch (word-addressed memory)
MAX_WAIT, 15, REQ cycles without mem_ready before fault; counter is $clog2(MAX_WAIT+1) bits

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  fetch request; sampled only in IDLE
pc_write  in  1  load PC from pc_in
pc_in  in  ADDR_W  branch/jump target
mem_rd  out  1  memory read request
mem_addr  out  ADDR_W  read address
mem_ready  in  1  memory read data valid this cycle
mem_data  in  DATA_W  memory read data
ir_data  out  DATA_W  instruction word to the IR input
ir_write  out  1  IR write strobe, one cycle per fetched word
pc_out  out  ADDR_W  current PC
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse, concurrent with ir_write
fault  out  1  one-cycle pulse on memory timeout

Behaviour:
- Reset (rst=1 at the edge, from any state): state=IDLE, pc=RESET_PC, ir_data=0, wait_cnt=0, pending-PC flag clear. mem_rd, ir_write, done, fault and busy are all 0 from the next cycle on.
- States are IDLE, REQ, LOAD and FAULT. All outputs are decoded from registered state. ir_data is a register.
- IDLE: if pc_write=1, pc<=pc_in. If start=1, go to REQ with wait_cnt=0. If both are high in the same cycle, the fetch uses pc_in: the PC update takes effect at that edge and REQ drives the new PC.
- REQ: mem_rd=1 and mem_addr=pc, both held stable until the request completes.
  - If mem_ready=1, ir_data<=mem_data and go to LOAD.
  - Otherwise wait_cnt increments. When wait_cnt reaches MAX_WAIT, go to FAULT.
- LOAD (one cycle): ir_write=1 and done=1, with ir_data stable. At the exit edge, pc<=pending target if the pending flag is set, else pc+PC_INC (modulo 2^ADDR_W). The pending flag clears. Next state is IDLE.
- FAULT (one cycle): fault=1. PC and ir_data are unchanged. The pending flag clears and pc<=pending target if set. Next state is IDLE.
- Minimum latency: start sampled at edge E0, then mem_rd is high in the cycle after E0. If mem_ready=1 in that cycle, ir_write is high in the cycle after E1 and the new pc_out is visible after E2. Each extra wait cycle adds 1.
- Outside IDLE, start is ignored and is not queued.
- pc_write while busy is deferred: pc_in is captured into a pending register and the flag is set; the last write wins. It is applied at the LOAD or FAULT exit and overrides the increment. mem_addr does not change mid-request.
- PC wrap: 16'hFFFF + 1 = 16'h0000. No flag is raised.
- mem_ready outside REQ is ignored. mem_data is sampled only in REQ when mem_ready=1.

Decomposition:
- Shared package: fetch-state enum (IDLE/REQ/LOAD/FAULT), ADDR_W and DATA_W defaults, RESET_PC constant. These are shared with the IR and control unit.
- One natural sub-module: pc_reg. It holds the PC with the load, increment, deferred-load and wrap logic. The FSM, wait counter and ir_data register stay in the top.

Test Plan:
- Reset then a single fetch: rst 2 cycles, start=1 for 1 cycle, mem_ready=1 on the first REQ cycle with mem_data=16'hA5C3 -> mem_addr=0x0000; ir_write and done high exactly 1 cycle with ir_data=16'hA5C3; pc_out=0x0001 afterward.
- Wait states: mem_ready delayed 3 cycles -> mem_rd and mem_addr stable for 4 cycles; ir_write appears 5 cycles after start is sampled; PC +1.
- Timeout: mem_ready held at 0 -> fault pulses once after MAX_WAIT=15 wait cycles; ir_write never asserts; pc_out unchanged; busy drops next cycle.
- Branch: pc_write=1 with pc_in=0x0040 and start=1 in the same IDLE cycle -> mem_addr=0x0040 and final pc=0x0041. A second case with pc_write during REQ, pc_in=0x0100 -> mem_addr unchanged and pc=0x0100 after LOAD.
- Wrap: pc loaded to 0xFFFF, fetch completes -> pc_out=0x0000.
- Reset mid-fetch: rst asserted in REQ -> mem_rd=0 and state IDLE next cycle; pc=RESET_PC; no ir_write; a later start fetches from 0x0000.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-path definitions: state encoding and default widths used by the
// fetch unit, the IR and the control unit.
package instr_fetch_unit_pkg;

  localparam int unsigned IFU_ADDR_W   = 16;
  localparam int unsigned IFU_DATA_W   = 16;
  localparam logic [15:0] IFU_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    LOAD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter: immediate load when idle, deferred load while a fetch is in
// flight, and modular increment when a fetched word retires.
module pc_reg
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned        ADDR_W   = IFU_ADDR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(IFU_RESET_PC),
  parameter int unsigned        PC_INC   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_write,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              idle,
  input  logic              commit,
  input  logic              advance,
  output logic [ADDR_W-1:0] pc_out
);

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pend_q;
  logic              pend_vld;

  // A write arriving in the commit cycle itself is the latest one, so it
  // beats an older pending target and the increment.
  always_comb begin
    pc_next = pc_q;
    if (idle && pc_write) begin
      pc_next = pc_in;
    end else if (commit) begin
      if (pc_write) begin
        pc_next = pc_in;
      end else if (pend_vld) begin
        pc_next = pend_q;
      end else if (advance) begin
        pc_next = pc_q + INC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      pend_q   <= '0;
      pend_vld <= 1'b0;
    end else begin
      pc_q <= pc_next;
      if (commit) begin
        pend_vld <= 1'b0;
      end else if (pc_write && !idle) begin
        pend_q   <= pc_in;
        pend_vld <= 1'b1;
      end
    end
  end

  assign pc_out = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads one word at the PC over a ready handshake,
// strobes it into the IR and advances the PC.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned        ADDR_W   = IFU_ADDR_W,
  parameter int unsigned        DATA_W   = IFU_DATA_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(IFU_RESET_PC),
  parameter int unsigned        PC_INC   = 1,
  parameter int unsigned        MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pc_write,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] ir_data,
  output logic              ir_write,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              done,
  output logic              fault
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  fetch_state_t      state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [DATA_W-1:0] ir_q;
  logic [ADDR_W-1:0] pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      ir_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= REQ;
            wait_cnt <= '0;
          end
        end
        REQ: begin
          if (mem_ready) begin
            ir_q  <= mem_data;
            state <= LOAD;
          end else begin
            // The MAX_WAIT-th unanswered request cycle is the last one.
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_LAST) begin
              state <= FAULT;
            end
          end
        end
        LOAD:    state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .PC_INC   (PC_INC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .pc_write (pc_write),
    .pc_in    (pc_in),
    .idle     (state == IDLE),
    .commit   ((state == LOAD) || (state == FAULT)),
    .advance  (state == LOAD),
    .pc_out   (pc)
  );

  // PC only moves in IDLE or at LOAD/FAULT exit, so it is a stable request address.
  assign mem_rd   = (state == REQ);
  assign mem_addr = pc;
  assign ir_data  = ir_q;
  assign ir_write = (state == LOAD);
  assign done     = (state == LOAD);
  assign fault    = (state == FAULT);
  assign busy     = (state != IDLE);
  assign pc_out   = pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: fetches with a scoreboard of
// expected (address, word) pairs, plus timeout, branch, wrap and reset cases.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, start, pc_write, mem_ready;
  logic [15:0] pc_in, mem_data;
  logic        mem_rd, ir_write, busy, done, fault;
  logic [15:0] mem_addr, ir_data, pc_out;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  logic        prev_rd   = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [15:0] req_addr  = '0;

  instr_fetch_unit #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .RESET_PC (16'h0000),
    .PC_INC   (1),
    .MAX_WAIT (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pc_write  (pc_write),
    .pc_in     (pc_in),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_data  (mem_data),
    .ir_data   (ir_data),
    .ir_write  (ir_write),
    .pc_out    (pc_out),
    .busy      (busy),
    .done      (done),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every IR write must match the oldest expected fetch.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd && prev_rd) check("addr_stable", mem_addr, prev_addr);
      if (mem_rd) req_addr = mem_addr;
      if (ir_write) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_ir_write", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_ir_data", ir_data, e.data);
          check("sb_req_addr", req_addr, e.addr);
        end
      end
      prev_rd   = mem_rd;
      prev_addr = mem_addr;
    end else begin
      prev_rd = 1'b0;
    end
  end

  // One fetch with 'waits' unanswered REQ cycles. start is held through REQ to
  // show it is not queued. Optional PC write with start or in the first REQ cycle.
  task automatic do_fetch(input logic [15:0] exp_addr, input logic [15:0] data,
                          input int waits, input logic wr_start, input logic wr_req,
                          input logic [15:0] wr_val);
    sb.push_back('{addr: exp_addr, data: data});
    start    = 1'b1;
    pc_write = wr_start;
    pc_in    = wr_val;
    tick();
    pc_write = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      check("req_mem_rd", mem_rd, 1);
      check("req_mem_addr", mem_addr, exp_addr);
      pc_write  = (i == 0) && wr_req;
      pc_in     = wr_val;
      mem_ready = (i == waits);
      mem_data  = (i == waits) ? data : 16'hDEAD;
      tick();
      pc_write = 1'b0;
    end
    mem_ready = 1'b0;
    start     = 1'b0;
    check("load_ir_write", ir_write, 1);
    check("load_done", done, 1);
    check("load_ir_data", ir_data, data);
    check("load_mem_rd", mem_rd, 0);
    tick();
    check("post_ir_write", ir_write, 0);
    check("post_done", done, 0);
    check("post_busy", busy, 0);
  endtask

  task automatic do_timeout(input logic [15:0] pc_exp, input logic wr_req,
                            input logic [15:0] wr_val, input logic [15:0] pc_after);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check("to_mem_rd", mem_rd, 1);
      check("to_fault_low", fault, 0);
      pc_write = (i == 2) && wr_req;
      pc_in    = wr_val;
      tick();
      pc_write = 1'b0;
    end
    check("to_fault", fault, 1);
    check("to_no_ir_write", ir_write, 0);
    check("to_mem_rd_low", mem_rd, 0);
    check("to_pc_held", pc_out, pc_exp);
    tick();
    check("to_fault_once", fault, 0);
    check("to_busy_drop", busy, 0);
    check("to_pc_after", pc_out, pc_after);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pc_write = 1'b0; pc_in = '0;
    mem_ready = 1'b0; mem_data = '0;
    tick();
    tick();
    check("rst_mem_rd", mem_rd, 0);
    check("rst_busy", busy, 0);
    check("rst_ir_write", ir_write, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_pc", pc_out, 16'h0000);
    check("rst_ir_data", ir_data, 16'h0000);
    rst = 1'b0;

    do_fetch(16'h0000, 16'hA5C3, 0, 1'b0, 1'b0, 16'h0000);
    check("single_pc", pc_out, 16'h0001);
    check("single_ir_hold", ir_data, 16'hA5C3);

    do_fetch(16'h0001, 16'h1234, 3, 1'b0, 1'b0, 16'h0000);
    check("wait_pc", pc_out, 16'h0002);

    do_timeout(16'h0002, 1'b0, 16'h0000, 16'h0002);
    check("timeout_ir_kept", ir_data, 16'h1234);

    do_fetch(16'h0040, 16'hBEEF, 1, 1'b1, 1'b0, 16'h0040);
    check("branch_same_pc", pc_out, 16'h0041);

    do_fetch(16'h0041, 16'h5A5A, 2, 1'b0, 1'b1, 16'h0100);
    check("branch_defer_pc", pc_out, 16'h0100);

    do_timeout(16'h0100, 1'b1, 16'h0200, 16'h0200);

    // mem_ready while idle must not disturb ir_data or start anything.
    mem_ready = 1'b1; mem_data = 16'hC0DE;
    tick();
    mem_ready = 1'b0;
    check("idle_ready_ir", ir_data, 16'h5A5A);
    check("idle_ready_busy", busy, 0);

    pc_write = 1'b1; pc_in = 16'hFFFF;
    tick();
    pc_write = 1'b0;
    check("wrap_load", pc_out, 16'hFFFF);
    do_fetch(16'hFFFF, 16'h0F0F, 0, 1'b0, 1'b0, 16'h0000);
    check("wrap_pc", pc_out, 16'h0000);

    pc_write = 1'b1; pc_in = 16'h0033;
    tick();
    pc_write = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("midrst_in_req", mem_rd, 1);
    check("midrst_addr", mem_addr, 16'h0033);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_mem_rd", mem_rd, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pc", pc_out, 16'h0000);
    tick();
    check("midrst_no_ir_write", ir_write, 0);
    do_fetch(16'h0000, 16'h7777, 0, 1'b0, 1'b0, 16'h0000);
    check("midrst_refetch_pc", pc_out, 16'h0001);

    tick();
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
